// File: rtl/mem_port_arbiter.sv
// Host/CPU arbiter for the shared single-port memory: registered commands, tagged read return, bounded host runs.
// Optional burst lock enabled by defining MEM_ARB_HOST_LOCK_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDR_SIZE    = 5,
    parameter int MAX_HOST_RUN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic                 h_lock,
    input  logic [ADDR_SIZE-1:0] h_addr,
    input  logic [DATA_SIZE-1:0] h_wdata,
    output logic                 h_gnt,
    output logic                 h_rvalid,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [ADDR_SIZE-1:0] c_addr,
    input  logic [DATA_SIZE-1:0] c_wdata,
    output logic                 c_gnt,
    output logic                 c_rvalid,
    output logic                 cpu_stall,
    output logic                 m_en,
    output logic                 m_we,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [DATA_SIZE-1:0] m_wdata,
    input  logic [DATA_SIZE-1:0] m_rdata,
    output logic [DATA_SIZE-1:0] rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOST, ST_CPU, ST_LOCK} state_t;

    localparam logic [3:0] MAX_RUN    = 4'(MAX_HOST_RUN);
    localparam int         TAG_STAGES = 2;
`ifdef MEM_ARB_HOST_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic [3:0] run_cnt_reg, run_cnt_next;
    logic       lock_req;

    // With the lock compiled out h_lock folds to zero, so LOCK can never be entered.
    assign lock_req = h_lock & LOCK_EN;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg   <= ST_IDLE;
            run_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    always_comb begin
        state_next   = ST_IDLE;
        run_cnt_next = run_cnt_reg;
        if (state_reg == ST_LOCK) begin
            state_next = lock_req ? ST_LOCK : ST_IDLE;
        end else begin
            if (h_gnt)
                state_next = lock_req ? ST_LOCK : ST_HOST;
            else if (c_gnt)
                state_next = ST_CPU;
            if (!c_req || c_gnt)
                run_cnt_next = 4'd0;
            else if (h_gnt && run_cnt_reg != MAX_RUN)
                run_cnt_next = run_cnt_reg + 4'd1;
        end
    end

    // Host has priority until it has used up its run while the CPU waits.
    always_comb begin
        h_gnt = 1'b0;
        c_gnt = 1'b0;
        if (state_reg == ST_LOCK)
            h_gnt = h_req;
        else if (c_req && (!h_req || run_cnt_reg == MAX_RUN))
            c_gnt = 1'b1;
        else
            h_gnt = h_req;
    end

    assign cpu_stall = c_req & ~c_gnt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            m_en <= h_gnt | c_gnt;
            m_we <= (h_gnt & h_we) | (c_gnt & c_we);
            if (h_gnt) begin
                m_addr  <= h_addr;
                m_wdata <= h_wdata;
            end else if (c_gnt) begin
                m_addr  <= c_addr;
                m_wdata <= c_wdata;
            end
        end
    end

    // Read-return tag follows the command so it lines up with m_rdata.
    for (genvar gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
        logic valid_in, host_in;
        logic valid_reg, host_reg;
        if (gi == 0) begin : g_head
            assign valid_in = (h_gnt & ~h_we) | (c_gnt & ~c_we);
            assign host_in  = h_gnt;
        end else begin : g_body
            assign valid_in = g_tag[gi-1].valid_reg;
            assign host_in  = g_tag[gi-1].host_reg;
        end
        always_ff @(posedge clk or posedge rstn) begin
            if (rstn) begin
                valid_reg <= 1'b0;
                host_reg  <= 1'b0;
            end else begin
                valid_reg <= valid_in;
                host_reg  <= host_in;
            end
        end
    end

    assign h_rvalid = g_tag[TAG_STAGES-1].valid_reg &  g_tag[TAG_STAGES-1].host_reg;
    assign c_rvalid = g_tag[TAG_STAGES-1].valid_reg & ~g_tag[TAG_STAGES-1].host_reg;
    assign rdata    = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected commands/reads, a monitor pops them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          h_req = 0, h_we = 0, h_lock = 0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          c_req = 0, c_we = 0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          h_gnt, h_rvalid, c_gnt, c_rvalid, cpu_stall;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, rdata;
    logic [DW-1:0] m_rdata = '0;

    mem_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MAX_HOST_RUN(4)) dut (
        .clk(clk), .rstn(rstn),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .cpu_stall(cpu_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the port: synchronous, read data one cycle after m_en.
    logic [DW-1:0] mem [0:31];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
    typedef struct { int cyc; logic host; logic [DW-1:0] data; } rd_t;
    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    cmd_t mc;
    rd_t  mr;
    logic [DW-1:0] ref_mem [0:31];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic host);
        cmd_q.push_back('{cyc + 1, we, addr, wd});
        if (we) ref_mem[addr] = wd;
        else    rd_q.push_back('{cyc + 2, host, ref_mem[addr]});
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(input logic hr, input logic hw, input logic hl, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input logic cr, input logic cw,
                        input logic [AW-1:0] ca, input logic eh, input logic ec);
        h_req = hr; h_we = hw; h_lock = hl; h_addr = ha; h_wdata = hd;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = 16'h0;
        @(negedge clk);
        $display("cyc %0d: h_req=%0b c_req=%0b h_gnt=%0b c_gnt=%0b stall=%0b", cyc, hr, cr, h_gnt, c_gnt, cpu_stall);
        chk("h_gnt", 32'(h_gnt), 32'(eh));
        chk("c_gnt", 32'(c_gnt), 32'(ec));
        chk("cpu_stall", 32'(cpu_stall), 32'(cr & ~ec));
        if (eh) push(hw, ha, hd, 1'b1);
        if (ec) push(cw, ca, 16'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_wdata", 32'(m_wdata), 0);
        chk("rst_h_rvalid", 32'(h_rvalid), 0);
        chk("rst_c_rvalid", 32'(c_rvalid), 0);
        chk("rst_gnt", 32'({h_gnt, c_gnt, cpu_stall}), 0);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            if (m_en) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd @cyc %0d: got m_en=1 addr=%h expected no command", cyc, m_addr);
                end else begin
                    mc = cmd_q.pop_front();
                    $display("cyc %0d: cmd we=%0b addr=%0d wdata=%h", cyc, m_we, m_addr, m_wdata);
                    chk("cmd_cycle", 32'(cyc), 32'(mc.cyc));
                    chk("cmd_we", 32'(m_we), 32'(mc.we));
                    chk("cmd_addr", 32'(m_addr), 32'(mc.addr));
                    if (mc.we) chk("cmd_wdata", 32'(m_wdata), 32'(mc.wdata));
                end
            end
            if (h_rvalid || c_rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid @cyc %0d: got h=%0b c=%0b expected none", cyc, h_rvalid, c_rvalid);
                end else begin
                    mr = rd_q.pop_front();
                    $display("cyc %0d: read h_rvalid=%0b c_rvalid=%0b rdata=%h", cyc, h_rvalid, c_rvalid, rdata);
                    chk("rd_cycle", 32'(cyc), 32'(mr.cyc));
                    chk("rd_owner", 32'({h_rvalid, c_rvalid}), mr.host ? 32'd2 : 32'd1);
                    chk("rd_data", 32'(rdata), 32'(mr.data));
                end
            end
        end
    end

    initial begin
        int hi;
        logic cw;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rstn = 1'b0;
        idle(1);

        // Host load of addresses 0..8.
        for (int a = 0; a < 9; a++) step(1, 1, 0, 5'(a), 16'h1000 + 16'(a), 0, 0, '0, 1, 0);
        idle(2);

        // CPU read at addr 3.
        step(0, 0, 0, '0, '0, 1, 0, 5'd3, 0, 1);
        idle(3);

        // Host read addr 1, CPU read addr 2 right behind.
        step(1, 0, 0, 5'd1, '0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, '0, 1, 0, 5'd2, 0, 1);
        idle(3);

        // Fairness: four host grants then one CPU grant, twice.
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            cw = (i % 5 == 4);
            step(1, 1, 0, 5'(16 + hi), 16'h2000 + 16'(hi), 1, 0, 5'd3, !cw, cw);
            if (!cw) hi++;
        end
        idle(3);

`ifdef MEM_ARB_HOST_LOCK_EN
        for (int i = 0; i < 8; i++) step(1, 1, 1, 5'(24 + i), 16'h3000 + 16'(i), 1, 0, 5'd8, 1, 0);
        step(0, 0, 0, '0, '0, 1, 0, 5'd8, 0, 0);
        step(0, 0, 0, '0, '0, 1, 0, 5'd8, 0, 1);
`else
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            cw = (i == 4);
            step(1, 1, 1, 5'(24 + hi), 16'h3000 + 16'(hi), (i <= 4), 0, 5'd8, !cw, cw);
            if (!cw) hi++;
        end
`endif
        idle(3);

        // Reset while a host read is in flight.
        step(1, 0, 0, 5'd5, '0, 0, 0, '0, 1, 0);
        rstn = 1'b1;
        cmd_q.delete();
        rd_q.delete();
        h_req = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rstn = 1'b0;
        idle(3);
        step(1, 0, 0, 5'd5, '0, 0, 0, '0, 1, 0);
        idle(4);

        chk("cmd_q_empty", 32'(cmd_q.size()), 0);
        chk("rd_q_empty", 32'(rd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU's single-port instruction/data memory. It shares the memory between the host loader and the CPU core, which uses the port for fetch and LD/ST. The host loader is the port that programs instruction words. The block sits between top_level's memory and both requesters. It issues registered memory commands, routes read data back to the owning requester, and bounds host bursts so the CPU is never starved.

## Interface
Parameters:
- DATA_SIZE, 16, memory word width
- ADDR_SIZE, 5, memory address width
- MAX_HOST_RUN, 4, max consecutive host grants while CPU is waiting (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-high
- h_req  in  1  host access request
- h_we  in  1  host write (1) / read (0)
- h_lock  in  1  host burst lock (see Configuration)
- h_addr  in  ADDR_SIZE  host address
- h_wdata  in  DATA_SIZE  host write data
- h_gnt  out  1  host request accepted this cycle (combinational)
- h_rvalid  out  1  host read data valid on rdata
- c_req, c_we, c_addr, c_wdata  in  1/1/ADDR_SIZE/DATA_SIZE  CPU request, same meaning as host
- c_gnt  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  CPU read data valid on rdata
- cpu_stall  out  1  c_req & ~c_gnt
- m_en, m_we  out  1  registered memory enable / write enable
- m_addr  out  ADDR_SIZE  registered memory address
- m_wdata  out  DATA_SIZE  registered memory write data
- m_rdata  in  DATA_SIZE  memory read data, valid 1 cycle after m_en
- rdata  out  DATA_SIZE  m_rdata passed through

## Operation
- At most one grant per cycle. A request is held until its grant; inputs must stay stable while waiting.
- FSM states: IDLE (no grant last cycle), HOST (host granted last), CPU (CPU granted last), LOCK (host owns the port under lock).
- Priority in IDLE/CPU/HOST: host wins, unless c_req=1 and run_cnt==MAX_HOST_RUN. In that case the CPU wins.
- run_cnt is 4 bits. It increments on each host grant while c_req=1 and clears on any CPU grant or when c_req=0. It saturates at MAX_HOST_RUN.
- The CPU is granted whenever c_req=1 and h_req=0.
- Transitions: any host grant goes to HOST, or to LOCK if lock is enabled and h_lock=1. A CPU grant goes to CPU. No grant goes to IDLE. LOCK stays LOCK while h_lock=1, and goes to IDLE when h_lock drops.
- In LOCK only the host can be granted, and run_cnt is held.
- The read return tag (owner, valid) is a 2-stage pipeline. rvalid is raised only for reads (we=0), never for writes.

## Timing
- Grant in cycle N. m_en/m_we/m_addr/m_wdata are driven in cycle N+1. rdata and the owner's rvalid are high in cycle N+2.
- Back-to-back grants give full throughput of 1 access per cycle, including alternating owners.
- Reset values: all outputs 0, FSM=IDLE, run_cnt=0, tag pipeline cleared.
- Reset asserted mid-operation: the in-flight command is dropped and no rvalid is issued after reset.
- Simultaneous h_req and c_req with run_cnt<MAX_HOST_RUN: host is granted and cpu_stall=1.

## Configuration
- MEM_ARB_HOST_LOCK_EN defined: h_lock is honoured, LOCK state exists, and CPU fairness is suspended while the lock is held.
- MEM_ARB_HOST_LOCK_EN undefined: h_lock is ignored, LOCK is unreachable, and fairness always applies.

## Test plan
- Reset: rstn=1 mid-read, then release → no rvalid, all m_* = 0, first grant follows a new request.
- Host load: host writes addr 0..8 with data such as 0x1002, consecutive, and no CPU request → 9 h_gnt cycles, m_we=1 with matching m_addr/m_wdata 1 cycle later.
- CPU read: c_req read at addr 3 after the load → c_gnt in cycle N, m_en in N+1, c_rvalid in N+2 with rdata equal to the stored word, and h_rvalid=0.
- Fairness: h_req and c_req held continuously with MAX_HOST_RUN=4 → 4 host grants, 1 CPU grant, repeating; cpu_stall high on the 4 host cycles.
- Lock (macro defined): h_lock=1 for 8 host writes while c_req=1 → no c_gnt for 8 cycles, CPU granted the cycle after h_lock drops. With the macro undefined, the CPU is granted after 4 host writes.
- Mixed reads: host read at addr 1 followed immediately by CPU read at addr 2 → h_rvalid in N+2, c_rvalid in N+3, each with the correct data.
